// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry defaults for the data cache controller.
//   state_e          controller FSM encoding (IDLE, REFILL, WRITE_MEM)
//   DEF_INDEX_BITS   default log2 of line count
//   DEF_OFFSET_BITS  default log2 of words per block
//   TAG_BITS         tag width for the default geometry
//   WORDS_PER_BLOCK  words per block for the default geometry
package dcache_pkg;
  localparam int unsigned DEF_INDEX_BITS = 4;
  localparam int unsigned DEF_OFFSET_BITS = 2;
  localparam int unsigned TAG_BITS = 30 - DEF_INDEX_BITS - DEF_OFFSET_BITS;
  localparam int unsigned WORDS_PER_BLOCK = 1 << DEF_OFFSET_BITS;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM} state_e;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/tag/data storage for a direct-mapped cache.
//   clk, rst_n        clock, async active-low clear of the valid vector
//   rd_index_i/word_i combinational lookup -> rd_valid_o, rd_tag_o, rd_data_o
//   wr_index_i/word_i single synchronous write port location
//   word_we_i         write wr_data_i into the addressed word
//   tag_set_i         write wr_tag_i and set the line valid
//   inv_i             clear the line's valid bit
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS,
  localparam int unsigned TAG_W = 30 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  rd_index_i,
  input  logic [OFFSET_BITS-1:0] rd_word_i,
  output logic                   rd_valid_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  output logic [31:0]            rd_data_o,
  input  logic [INDEX_BITS-1:0]  wr_index_i,
  input  logic [OFFSET_BITS-1:0] wr_word_i,
  input  logic [31:0]            wr_data_i,
  input  logic                   word_we_i,
  input  logic [TAG_W-1:0]       wr_tag_i,
  input  logic                   tag_set_i,
  input  logic                   inv_i
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned WORDS = 1 << OFFSET_BITS;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES][WORDS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else if (tag_set_i) valid_q[wr_index_i] <= 1'b1;
    else if (inv_i) valid_q[wr_index_i] <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (word_we_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
    if (tag_set_i) tag_q[wr_index_i] <= wr_tag_i;
  end
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o = tag_q[rd_index_i];
  assign rd_data_o = data_q[rd_index_i][rd_word_i];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-through, no-write-allocate data cache.
//   clk, reset                      clock, async active-low reset
//   cpu_addr/wdata/mem_read/write   core data port request
//   cpu_rdata, cpu_stall            load data, core hold
//   mm_addr/wdata/read/write        word-wide main-memory request
//   mm_rdata, mm_ready              main-memory read data, completion pulse
// DCACHE_WRITE_BUFFER_EN: when defined, writes are posted through a one-entry
// buffer drained in WRITE_MEM while the core keeps running.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  output logic        mm_read,
  output logic        mm_write,
  input  logic [31:0] mm_rdata,
  input  logic        mm_ready
);
  localparam int unsigned TAG_W = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned BLK_W = 30 - OFFSET_BITS;
`ifdef DCACHE_WRITE_BUFFER_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif
  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;
  logic [BLK_W-1:0]       blk_q, blk_d;
  logic [31:0]            addr_q, addr_d, wdata_q, wdata_d;
  logic                   rd_valid, hit, word_we, tag_set, inv, refilling;
  logic [TAG_W-1:0]       rd_tag;
  logic [31:0]            rd_data;
  wire [TAG_W-1:0]        c_tag = cpu_addr[31 -: TAG_W];
  wire [INDEX_BITS-1:0]   c_index = cpu_addr[2+OFFSET_BITS +: INDEX_BITS];
  wire [OFFSET_BITS-1:0]  c_word = cpu_addr[2 +: OFFSET_BITS];
  assign hit = rd_valid && (rd_tag == c_tag);
  assign cpu_rdata = hit ? rd_data : '0;
  assign refilling = (state_q == REFILL);
  // The write port is shared: refill beats target the latched block, stores target the core's address.
  dcache_line_array #(.INDEX_BITS(INDEX_BITS), .OFFSET_BITS(OFFSET_BITS)) u_lines (
    .clk        (clk),
    .rst_n      (reset),
    .rd_index_i (c_index),
    .rd_word_i  (c_word),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_index_i (refilling ? blk_q[INDEX_BITS-1:0] : c_index),
    .wr_word_i  (refilling ? beat_q : c_word),
    .wr_data_i  (refilling ? mm_rdata : cpu_wdata),
    .word_we_i  (word_we),
    .wr_tag_i   (blk_q[BLK_W-1 -: TAG_W]),
    .tag_set_i  (tag_set),
    .inv_i      (inv)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q <= '0;
      blk_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      blk_q <= blk_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    blk_d = blk_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cpu_stall = 1'b0;
    mm_read = 1'b0;
    mm_write = 1'b0;
    mm_addr = '0;
    mm_wdata = '0;
    word_we = 1'b0;
    tag_set = 1'b0;
    inv = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_mem_write) begin
          addr_d = cpu_addr;
          wdata_d = cpu_wdata;
          word_we = hit;
          cpu_stall = !WBUF;
          state_d = WRITE_MEM;
        end else if (cpu_mem_read && !hit) begin
          // The victim goes invalid now so a refill cut short never leaves a stale-tagged line.
          cpu_stall = 1'b1;
          blk_d = cpu_addr[31:2+OFFSET_BITS];
          beat_d = '0;
          inv = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mm_read = 1'b1;
        mm_addr = {blk_q, beat_q, 2'b00};
        if (mm_ready) begin
          word_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (&beat_q) begin
            tag_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WRITE_MEM: begin
        mm_write = 1'b1;
        mm_addr = addr_q;
        mm_wdata = wdata_q;
        if (!WBUF) begin
          cpu_stall = !mm_ready;
          if (mm_ready) state_d = IDLE;
        end else if (cpu_mem_write) begin
          // A store behind a full buffer is accepted on the drain's completion edge.
          cpu_stall = !mm_ready;
          if (mm_ready) begin
            addr_d = cpu_addr;
            wdata_d = cpu_wdata;
            word_we = hit;
          end
        end else begin
          cpu_stall = cpu_mem_read && !hit;
          if (mm_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed self-checking bench for dcache_controller.
module tb_dcache_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_mem_read = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [31:0] cpu_rdata, mm_addr, mm_wdata, mm_rdata;
  logic        cpu_stall, mm_read, mm_write, mm_ready;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [1024];
  logic [31:0] log_addr [128];
  logic [31:0] log_data [128];
  logic        log_wr [128];
  int          n_log = 0;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .mm_addr       (mm_addr),
    .mm_wdata      (mm_wdata),
    .mm_read       (mm_read),
    .mm_write      (mm_write),
    .mm_rdata      (mm_rdata),
    .mm_ready      (mm_ready)
  );

  // Main memory: raises mm_ready for one cycle two cycles after each request starts.
  initial begin
    int cnt;
    cnt = 0;
    mm_ready = 1'b0;
    mm_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[16] = 32'h11;
    mem[17] = 32'h22;
    mem[18] = 32'h33;
    mem[19] = 32'h44;
    forever begin
      @(posedge clk);
      #1;
      if (mm_ready) begin
        mm_ready = 1'b0;
        cnt = (reset && (mm_read || mm_write)) ? 1 : 0;
      end else if (reset && (mm_read || mm_write)) begin
        cnt++;
        if (cnt == 2) begin
          cnt = 0;
          mm_ready = 1'b1;
          if (mm_write) mem[mm_addr[11:2]] = mm_wdata;
          else mm_rdata = mem[mm_addr[11:2]];
          if (n_log < 128) begin
            log_addr[n_log] = mm_addr;
            log_wr[n_log] = mm_write;
            log_data[n_log] = mm_write ? mm_wdata : mm_rdata;
          end
          n_log++;
        end
      end else cnt = 0;
    end
  end

  // Issues one core access and counts the stalled cycles before the core is released.
  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic [31:0] rdata);
    @(negedge clk);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_mem_read = rd;
    cpu_mem_write = wr;
    cyc = 0;
    #1;
    while (cpu_stall && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    rdata = cpu_rdata;
    @(posedge clk);
    #2;
    cpu_mem_read = 1'b0;
    cpu_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    checks++; if (mm_read !== 1'b0) begin errors++; $display("FAIL reset_mm_read: got %b want 0", mm_read); end
    checks++; if (mm_write !== 1'b0) begin errors++; $display("FAIL reset_mm_write: got %b want 0", mm_write); end
    checks++; if (mm_addr !== 32'h0) begin errors++; $display("FAIL reset_mm_addr: got %h want 0", mm_addr); end
    checks++; if (mm_wdata !== 32'h0) begin errors++; $display("FAIL reset_mm_wdata: got %h want 0", mm_wdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall: got %b want 0", cpu_stall); end
    cpu_addr = 32'h40;
    cpu_mem_read = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_miss_stall: got %b want 1", cpu_stall); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_miss_rdata: got %h want 0", cpu_rdata); end
    cpu_mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_refill();
    int cyc, base;
    logic [31:0] rd;
    base = n_log;
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd);
    checks++; if (cyc != 9) begin errors++; $display("FAIL refill_stall_cycles: got %0d want 9", cyc); end
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL refill_rdata: got %h want 00000011", rd); end
    checks++; if (n_log - base != 4) begin errors++; $display("FAIL refill_beats: got %0d want 4", n_log - base); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      ea = 32'h40 + 32'(i * 4);
      checks++;
      if (log_addr[base+i] !== ea || log_wr[base+i] !== 1'b0) begin
        errors++; $display("FAIL refill_beat%0d: got addr %h wr %b want addr %h wr 0", i, log_addr[base+i], log_wr[base+i], ea);
      end
    end
  endtask

  task automatic test_hit();
    int cyc, base;
    logic [31:0] rd;
    base = n_log;
    cpu_op(1'b1, 1'b0, 32'h44, 32'h0, cyc, rd);
    checks++; if (cyc != 0) begin errors++; $display("FAIL hit_stall_cycles: got %0d want 0", cyc); end
    checks++; if (rd !== 32'h22) begin errors++; $display("FAIL hit_rdata: got %h want 00000022", rd); end
    checks++; if (n_log != base) begin errors++; $display("FAIL hit_mm_activity: got %0d want 0", n_log - base); end
  endtask

  task automatic test_write_hit();
    int cyc, base;
    logic [31:0] rd;
    base = n_log;
    cpu_op(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, cyc, rd);
    checks++; if (cyc != 2) begin errors++; $display("FAIL wr_hit_stall_cycles: got %0d want 2", cyc); end
    checks++; if (n_log - base != 1) begin errors++; $display("FAIL wr_hit_count: got %0d want 1", n_log - base); end
    checks++;
    if (log_addr[base] !== 32'h48 || log_data[base] !== 32'hDEADBEEF || log_wr[base] !== 1'b1) begin
      errors++; $display("FAIL wr_hit_txn: got addr %h data %h wr %b want 00000048 deadbeef 1", log_addr[base], log_data[base], log_wr[base]);
    end
    cpu_op(1'b1, 1'b0, 32'h48, 32'h0, cyc, rd);
    checks++; if (cyc != 0) begin errors++; $display("FAIL wr_hit_readback_cycles: got %0d want 0", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hit_readback: got %h want deadbeef", rd); end
  endtask

  task automatic test_write_miss();
    int cyc, base;
    logic [31:0] rd;
    base = n_log;
    cpu_op(1'b0, 1'b1, 32'h100, 32'hCAFE0100, cyc, rd);
    checks++; if (cyc != 2) begin errors++; $display("FAIL wr_miss_stall_cycles: got %0d want 2", cyc); end
    checks++; if (n_log - base != 1 || log_wr[base] !== 1'b1) begin errors++; $display("FAIL wr_miss_txn: got %0d txns wr %b want 1 write", n_log - base, log_wr[base]); end
    base = n_log;
    cpu_op(1'b1, 1'b0, 32'h100, 32'h0, cyc, rd);
    checks++; if (cyc != 9) begin errors++; $display("FAIL wr_miss_noalloc: got %0d stall cycles want 9", cyc); end
    checks++; if (rd !== 32'hCAFE0100) begin errors++; $display("FAIL wr_miss_refill_data: got %h want cafe0100", rd); end
    checks++; if (log_addr[base] !== 32'h100 || log_addr[base+3] !== 32'h10C) begin errors++; $display("FAIL wr_miss_refill_addrs: got %h..%h want 00000100..0000010c", log_addr[base], log_addr[base+3]); end
    cpu_op(1'b1, 1'b0, 32'h104, 32'h0, cyc, rd);
    checks++; if (cyc != 0 || rd !== 32'h1000_0041) begin errors++; $display("FAIL wr_miss_neighbor: got %0d cycles data %h want 0 cycles 10000041", cyc, rd); end
  endtask

  task automatic test_conflict();
    int cyc, base;
    logic [31:0] rd;
    base = n_log;
    cpu_op(1'b1, 1'b0, 32'h440, 32'h0, cyc, rd);
    checks++; if (cyc != 9) begin errors++; $display("FAIL conflict_miss_cycles: got %0d want 9", cyc); end
    checks++; if (rd !== 32'h1000_0110) begin errors++; $display("FAIL conflict_rdata: got %h want 10000110", rd); end
    checks++; if (log_addr[base] !== 32'h440 || log_addr[base+3] !== 32'h44C) begin errors++; $display("FAIL conflict_addrs: got %h..%h want 00000440..0000044c", log_addr[base], log_addr[base+3]); end
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd);
    checks++; if (cyc != 9) begin errors++; $display("FAIL conflict_evicted: got %0d stall cycles want 9", cyc); end
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL conflict_reload: got %h want 00000011", rd); end
    cpu_op(1'b1, 1'b0, 32'h48, 32'h0, cyc, rd);
    checks++; if (cyc != 0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_writethrough: got %0d cycles data %h want 0 cycles deadbeef", cyc, rd); end
  endtask

  task automatic test_both();
    int cyc, base;
    logic [31:0] rd;
    base = n_log;
    cpu_op(1'b1, 1'b1, 32'h44, 32'h5555AAAA, cyc, rd);
    checks++; if (cyc != 2) begin errors++; $display("FAIL both_stall_cycles: got %0d want 2", cyc); end
    checks++; if (n_log - base != 1 || log_wr[base] !== 1'b1 || log_addr[base] !== 32'h44) begin errors++; $display("FAIL both_write_wins: got %0d txns wr %b addr %h want 1 write at 00000044", n_log - base, log_wr[base], log_addr[base]); end
    cpu_op(1'b1, 1'b0, 32'h44, 32'h0, cyc, rd);
    checks++; if (cyc != 0 || rd !== 32'h5555AAAA) begin errors++; $display("FAIL both_readback: got %0d cycles data %h want 0 cycles 5555aaaa", cyc, rd); end
  endtask

  task automatic test_reset_mid_refill();
    int cyc, base, k;
    logic [31:0] rd;
    cpu_op(1'b1, 1'b0, 32'h440, 32'h0, cyc, rd);
    checks++; if (cyc != 9) begin errors++; $display("FAIL midrst_evict: got %0d stall cycles want 9", cyc); end
    base = n_log;
    @(negedge clk);
    cpu_addr = 32'h40;
    cpu_mem_read = 1'b1;
    k = 0;
    while (!(mm_read === 1'b1 && mm_addr === 32'h48) && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 100) begin errors++; $display("FAIL midrst_beat2_timeout: got %0d cycles want <100", k); end
    checks++; if (n_log - base != 2) begin errors++; $display("FAIL midrst_beats_before: got %0d want 2", n_log - base); end
    #1 reset = 1'b0;
    #1;
    checks++; if (mm_read !== 1'b0) begin errors++; $display("FAIL midrst_mm_read: got %b want 0", mm_read); end
    checks++; if (mm_addr !== 32'h0) begin errors++; $display("FAIL midrst_mm_addr: got %h want 0", mm_addr); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL midrst_invalid: got %h want 0", cpu_rdata); end
    cpu_mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    base = n_log;
    cpu_op(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd);
    checks++; if (cyc != 9 || rd !== 32'h11) begin errors++; $display("FAIL midrst_restart: got %0d cycles data %h want 9 cycles 00000011", cyc, rd); end
    checks++; if (log_addr[base] !== 32'h40 || n_log - base != 4) begin errors++; $display("FAIL midrst_beat0: got first %h count %0d want 00000040 count 4", log_addr[base], n_log - base); end
    cpu_op(1'b1, 1'b0, 32'h100, 32'h0, cyc, rd);
    checks++; if (cyc != 9 || rd !== 32'hCAFE0100) begin errors++; $display("FAIL midrst_all_invalid: got %0d cycles data %h want 9 cycles cafe0100", cyc, rd); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_both();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
